mac_r_frame_fetch: RTL and testbench
====================================

MAC_R_FRAME_FETCH -- requirements
Module: mac_r_frame_fetch

Interface
REQ-001 SHALL have parameter MTU, default 1500: payload MTU, so the maximum accepted frame is MTU+18 bytes.
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; every port is synchronous to it.
REQ-004 SHALL have port rst_sys, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ptr_fifo_empty, input, 1 bit: the rx descriptor FIFO is empty.
REQ-006 SHALL have port ptr_fifo_rd, output, 1 bit: descriptor FIFO read strobe.
REQ-007 SHALL have port ptr_fifo_dout, input, 16 bits: descriptor. [12:0] = length-1, [14] = length error, [15] = CRC error.
REQ-008 SHALL have port data_fifo_rd, output, 1 bit: frame byte FIFO read strobe.
REQ-009 SHALL have port data_fifo_dout, input, 8 bits: frame byte.
REQ-010 SHALL have port out_data, output, 8 bits: frame byte to downstream.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 SHALL have port out_sof, output, 1 bit: first byte of the frame.
REQ-013 SHALL have port out_eof, output, 1 bit: last byte of the frame.
REQ-014 SHALL have port out_ready, input, 1 bit: downstream accepts the byte.
REQ-015 SHALL have port out_len, output, 13 bits: frame length in bytes, valid while out_sof is high.
REQ-016 SHALL have port hdr_dmac, output, 48 bits: destination MAC of the current frame.
REQ-017 SHALL have port hdr_etype, output, 16 bits: EtherType of the current frame.
REQ-018 SHALL have port hdr_valid, output, 1 bit: one-cycle pulse when hdr_dmac and hdr_etype are complete.
REQ-019 SHALL have port cnt_good, output, CNT_W bits: count of frames forwarded.
REQ-020 SHALL have port cnt_drop, output, CNT_W bits: count of frames discarded.

Function
REQ-021 Both FIFOs SHALL be treated as standard-mode FIFOs: dout is valid exactly 1 cycle after rd.
REQ-022 The FSM SHALL have states IDLE, PTR_WAIT, LOAD, XFER, DRAIN, FLUSH.
- IDLE -> PTR_WAIT when ptr_fifo_empty=0; ptr_fifo_rd is high for exactly 1 cycle.
- PTR_WAIT -> LOAD unconditionally.
- LOAD latches the descriptor and computes len = desc[12:0]+1 in 14-bit arithmetic.
REQ-023 A frame SHALL be bad when desc[15] | desc[14] | (len > MTU+18); LOAD -> DRAIN if bad, else LOAD -> XFER.
REQ-024 In DRAIN, data_fifo_rd SHALL be high every cycle for exactly len cycles, regardless of out_ready; no bytes are output; cnt_drop increments once per frame.
REQ-025 In XFER, data_fifo_rd SHALL be high only while remaining>0 and (skid occupancy + reads in flight) < 2.
REQ-026 In XFER, exactly len reads SHALL be issued; each returned byte is pushed into the 2-entry skid buffer.
REQ-027 out_valid SHALL be high whenever the skid buffer is non-empty; a byte pops when out_valid & out_ready.
REQ-028 The bytes SHALL leave in order with no loss or duplication under any out_ready pattern.
REQ-029 out_sof SHALL mark output byte 0, with out_len = len; out_eof SHALL mark byte len-1. For len=1 both are set on the same byte.
REQ-030 The header SHALL be captured at FIFO-return time for good frames: bytes 0..5 -> hdr_dmac (byte 0 = [47:40]); bytes 12..13 -> hdr_etype (byte 12 = [15:8]).
REQ-031 hdr_valid SHALL pulse 1 cycle after byte 13 returns; there is no pulse when len<14.
REQ-032 XFER -> FLUSH after the last read is issued; FLUSH -> IDLE when the skid buffer is empty and no read is in flight; cnt_good increments on the FLUSH exit.
REQ-033 DRAIN -> IDLE SHALL occur 1 cycle after the last read. There is at least 1 IDLE cycle between frames.
REQ-034 Counters SHALL saturate at all-ones; no wrap.
REQ-035 The block SHALL rely on the rx side writing the descriptor only after all frame data is in the FIFO; it SHALL NOT monitor data_fifo empty.
REQ-036 ptr_fifo_rd and data_fifo_rd SHALL never be high in the same cycle.

Reset
REQ-037 While rst_sys is high, every output SHALL be 0 (strobes, out_*, hdr_*, counters), the FSM SHALL be in IDLE, and the skid buffer SHALL be empty.
REQ-038 Reset mid-frame SHALL abandon the frame without flushing the FIFOs; the FIFOs are reset by their owner.

Structure
REQ-039 A shared package SHALL hold: the FSM state enum; descriptor field positions (LEN_MSB=12, LENERR_BIT=14, CRCERR_BIT=15); and header offsets (DMAC 0..5, ETYPE 12..13).
REQ-040 The 2-entry skid buffer SHALL be a sub-module, mac_r_fetch_skid, exposing push, pop, data, sof/eof tags and a count.

Verification
REQ-041 Good 64-byte frame, desc=16'h003F, out_ready=1: 64 bytes out in order; sof on byte 0 with out_len=64; eof on byte 63; hdr_valid once; cnt_good=1.
REQ-042 CRC error, desc=16'h803F: exactly 64 data_fifo_rd cycles; out_valid stays 0; cnt_drop=1; the next good frame passes intact.
REQ-043 Good 100-byte frame with out_ready toggling at random (30% duty): output byte sequence is identical to input; data_fifo_rd is never issued with 2 entries pending.
REQ-044 len=1 frame, desc=16'h0000: one output byte with sof=eof=1; no hdr_valid.
REQ-045 Oversize frame, desc=16'h05F2 (1523 bytes): dropped, 1523 reads issued; then rst_sys is pulsed mid-XFER of the following frame, and all outputs are 0 and the FSM is in IDLE within 1 cycle.

Source files
------------

// File: rtl/mac_r_frame_fetch_pkg.sv
// Shared types and constants for the rx frame fetch block: FSM states,
// descriptor field positions and Ethernet header byte offsets.
package mac_r_frame_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PTR_WAIT,
    LOAD,
    XFER,
    DRAIN,
    FLUSH
  } state_t;

  localparam int LEN_MSB    = 12;
  localparam int LENERR_BIT = 14;
  localparam int CRCERR_BIT = 15;

  localparam int DMAC_FIRST  = 0;
  localparam int DMAC_LAST   = 5;
  localparam int ETYPE_FIRST = 12;
  localparam int ETYPE_LAST  = 13;

  localparam int LEN_W = 14;

  // One extra bit so a descriptor of 13'h1FFF still yields 8192 without wrapping.
  function automatic logic [LEN_W-1:0] desc_len(input logic [15:0] desc);
    return {1'b0, desc[LEN_MSB:0]} + LEN_W'(1);
  endfunction

endpackage

// File: rtl/mac_r_frame_fetch_if.sv
// Bundles the descriptor FIFO, data FIFO, output stream, header and statistics
// signals of the frame fetch block.
interface mac_r_frame_fetch_if #(
  parameter int CNT_W = 16
);

  logic             ptr_fifo_empty;
  logic             ptr_fifo_rd;
  logic [15:0]      ptr_fifo_dout;
  logic             data_fifo_rd;
  logic [7:0]       data_fifo_dout;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             out_ready;
  logic [12:0]      out_len;
  logic [47:0]      hdr_dmac;
  logic [15:0]      hdr_etype;
  logic             hdr_valid;
  logic [CNT_W-1:0] cnt_good;
  logic [CNT_W-1:0] cnt_drop;

  modport master (
    input  ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, out_ready,
    output ptr_fifo_rd, data_fifo_rd, out_data, out_valid, out_sof, out_eof,
           out_len, hdr_dmac, hdr_etype, hdr_valid, cnt_good, cnt_drop
  );

  modport slave (
    output ptr_fifo_empty, ptr_fifo_dout, data_fifo_dout, out_ready,
    input  ptr_fifo_rd, data_fifo_rd, out_data, out_valid, out_sof, out_eof,
           out_len, hdr_dmac, hdr_etype, hdr_valid, cnt_good, cnt_drop
  );

endinterface

// File: rtl/mac_r_fetch_skid.sv
// Two-entry elastic buffer between the data FIFO return path and the output
// stream; each entry carries the byte plus its start/end-of-frame tags.
module mac_r_fetch_skid (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_sof,
  input  logic       push_eof,
  input  logic       pop,
  output logic [7:0] data,
  output logic       sof,
  output logic       eof,
  output logic [1:0] count
);

  logic [9:0] entry [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count_q;
  logic       do_pop;
  logic       not_empty;
  logic [9:0] head;

  assign not_empty = (count_q != 2'd0);
  assign do_pop    = pop && not_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry[0] <= '0;
      entry[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_ptr] <= {push_sof, push_eof, push_data};
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Tags are masked when empty so a stale entry never looks like a frame edge.
  assign head  = entry[rd_ptr];
  assign data  = head[7:0];
  assign eof   = head[8] & not_empty;
  assign sof   = head[9] & not_empty;
  assign count = count_q;

endmodule

// File: rtl/mac_r_frame_fetch.sv
// Pulls a descriptor and its frame bytes from the rx FIFOs, discards bad
// frames and streams good ones downstream while snooping DMAC and EtherType.
module mac_r_frame_fetch
  import mac_r_frame_fetch_pkg::*;
#(
  parameter int MTU   = 1500,
  parameter int CNT_W = 16
) (
  input logic                 clk,
  input logic                 rst_sys,
  mac_r_frame_fetch_if.master bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MTU + 18);

  state_t           state;
  state_t           state_next;
  logic             ptr_rd;
  logic             data_rd;
  logic             xfer_rd;
  logic [LEN_W-1:0] load_len;
  logic             load_bad;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] remain_q;
  logic [LEN_W-1:0] ret_idx_q;
  logic             inflight_q;
  logic [2:0]       pending;
  logic [47:0]      dmac_q;
  logic [15:0]      etype_q;
  logic             hdr_valid_q;
  logic [CNT_W-1:0] cnt_good_q;
  logic [CNT_W-1:0] cnt_drop_q;
  logic             good_done;
  logic             drop_done;
  logic             out_valid;
  logic             skid_pop;
  logic             push_sof;
  logic             push_eof;
  logic [1:0]       skid_count;
  logic [7:0]       skid_data;
  logic             skid_sof;
  logic             skid_eof;

  assign load_len = desc_len(bus.ptr_fifo_dout);
  assign load_bad = bus.ptr_fifo_dout[CRCERR_BIT] | bus.ptr_fifo_dout[LENERR_BIT] |
                    (load_len > MAX_LEN);
  assign pending  = {1'b0, skid_count} + {2'b00, inflight_q};

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Reads in XFER are throttled so every returning byte is guaranteed a skid slot.
  always_comb begin
    state_next = state;
    ptr_rd     = 1'b0;
    xfer_rd    = 1'b0;
    data_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.ptr_fifo_empty) begin
          state_next = PTR_WAIT;
        end
      end
      PTR_WAIT: begin
        ptr_rd     = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        state_next = load_bad ? DRAIN : XFER;
      end
      XFER: begin
        xfer_rd = (remain_q != '0) && (pending < 3'd2);
        data_rd = xfer_rd;
        if (xfer_rd && (remain_q == LEN_W'(1))) begin
          state_next = FLUSH;
        end
      end
      DRAIN: begin
        data_rd = 1'b1;
        if (remain_q == LEN_W'(1)) begin
          state_next = IDLE;
        end
      end
      FLUSH: begin
        if ((skid_count == 2'd0) && !inflight_q) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign good_done = (state == FLUSH) && (state_next == IDLE);
  assign drop_done = (state == DRAIN) && (state_next == IDLE);

  // Header bytes shift in as they return, so byte 0 ends up in the top octet.
  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      len_q       <= '0;
      remain_q    <= '0;
      ret_idx_q   <= '0;
      inflight_q  <= 1'b0;
      dmac_q      <= '0;
      etype_q     <= '0;
      hdr_valid_q <= 1'b0;
    end else begin
      inflight_q  <= xfer_rd;
      hdr_valid_q <= inflight_q && (ret_idx_q == LEN_W'(ETYPE_LAST));
      if (state == LOAD) begin
        len_q     <= load_len;
        remain_q  <= load_len;
        ret_idx_q <= '0;
      end else begin
        if (data_rd) begin
          remain_q <= remain_q - LEN_W'(1);
        end
        if (inflight_q) begin
          ret_idx_q <= ret_idx_q + LEN_W'(1);
        end
      end
      if (inflight_q && (ret_idx_q <= LEN_W'(DMAC_LAST))) begin
        dmac_q <= {dmac_q[39:0], bus.data_fifo_dout};
      end
      if (inflight_q && (ret_idx_q >= LEN_W'(ETYPE_FIRST)) &&
          (ret_idx_q <= LEN_W'(ETYPE_LAST))) begin
        etype_q <= {etype_q[7:0], bus.data_fifo_dout};
      end
    end
  end

  always_ff @(posedge clk or posedge rst_sys) begin
    if (rst_sys) begin
      cnt_good_q <= '0;
      cnt_drop_q <= '0;
    end else begin
      if (good_done && (cnt_good_q != {CNT_W{1'b1}})) begin
        cnt_good_q <= cnt_good_q + CNT_W'(1);
      end
      if (drop_done && (cnt_drop_q != {CNT_W{1'b1}})) begin
        cnt_drop_q <= cnt_drop_q + CNT_W'(1);
      end
    end
  end

  assign push_sof  = (ret_idx_q == '0);
  assign push_eof  = (ret_idx_q == (len_q - LEN_W'(1)));
  assign out_valid = (skid_count != 2'd0);
  assign skid_pop  = out_valid && bus.out_ready;

  mac_r_fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst_sys),
    .push      (inflight_q),
    .push_data (bus.data_fifo_dout),
    .push_sof  (push_sof),
    .push_eof  (push_eof),
    .pop       (skid_pop),
    .data      (skid_data),
    .sof       (skid_sof),
    .eof       (skid_eof),
    .count     (skid_count)
  );

  assign bus.ptr_fifo_rd  = ptr_rd;
  assign bus.data_fifo_rd = data_rd;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = skid_data;
  assign bus.out_sof      = skid_sof;
  assign bus.out_eof      = skid_eof;
  assign bus.out_len      = skid_sof ? len_q[12:0] : 13'd0;
  assign bus.hdr_dmac     = dmac_q;
  assign bus.hdr_etype    = etype_q;
  assign bus.hdr_valid    = hdr_valid_q;
  assign bus.cnt_good     = cnt_good_q;
  assign bus.cnt_drop     = cnt_drop_q;

endmodule

// File: tb/tb_mac_r_frame_fetch.sv
// Directed bench for mac_r_frame_fetch: models both rx FIFOs in standard mode,
// records the output stream and compares it against hand-computed frames.
module tb_mac_r_frame_fetch;

  logic clk = 1'b0;
  logic rst_sys;

  mac_r_frame_fetch_if #(.CNT_W(16)) bus ();

  mac_r_frame_fetch #(.MTU(1500), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_sys (rst_sys),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] ptr_mem  [0:15];
  logic [7:0]  data_mem [0:4095];
  int ptr_wp  = 0;
  int ptr_rp  = 0;
  int data_wp = 0;
  int data_rp = 0;

  assign bus.ptr_fifo_empty = (ptr_rp == ptr_wp);

  // FIFO owner: dout follows rd by one cycle, and reset empties both FIFOs.
  always @(posedge clk) begin
    if (rst_sys) begin
      ptr_rp              <= ptr_wp;
      data_rp             <= data_wp;
      bus.ptr_fifo_dout   <= 16'h0000;
      bus.data_fifo_dout  <= 8'h00;
    end else begin
      if (bus.ptr_fifo_rd) begin
        bus.ptr_fifo_dout <= ptr_mem[ptr_rp % 16];
        ptr_rp            <= ptr_rp + 1;
      end
      if (bus.data_fifo_rd) begin
        bus.data_fifo_dout <= data_mem[data_rp % 4096];
        data_rp            <= data_rp + 1;
      end
    end
  end

  int          rd_count   = 0;
  int          valid_seen = 0;
  int          both_hi    = 0;
  int          pend       = 0;
  int          pend_viol  = 0;
  int          hdr_pulses = 0;
  logic [47:0] last_dmac  = '0;
  logic [15:0] last_etype = '0;
  bit          track_pend = 1'b0;
  logic [7:0]  got_data [$];
  bit          got_sof  [$];
  bit          got_eof  [$];
  int          got_len  [$];

  always @(negedge clk) begin
    if (!rst_sys) begin
      if (bus.data_fifo_rd) rd_count++;
      if (bus.ptr_fifo_rd && bus.data_fifo_rd) both_hi++;
      if (bus.out_valid) valid_seen++;
      if (bus.hdr_valid) begin
        hdr_pulses++;
        last_dmac  = bus.hdr_dmac;
        last_etype = bus.hdr_etype;
      end
      if (track_pend) begin
        if (bus.data_fifo_rd && (pend >= 2)) pend_viol++;
        pend = pend + (bus.data_fifo_rd ? 1 : 0) - ((bus.out_valid && bus.out_ready) ? 1 : 0);
      end else begin
        pend = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_sof.push_back(bus.out_sof);
        got_eof.push_back(bus.out_eof);
        got_len.push_back(int'(bus.out_len));
      end
    end
  end

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] desc, input int nbytes,
                               input logic [7:0] start, input logic [7:0] stride);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      b = start + 8'(i) * stride;
      data_mem[data_wp % 4096] = b;
      data_wp++;
    end
    ptr_mem[ptr_wp % 16] = desc;
    ptr_wp++;
  endtask

  task automatic wait_bytes(input int target, input int budget, input bit rnd);
    int left;
    left = budget;
    while ((got_data.size() < target) && (left > 0)) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 9) < 3);
      tick(1);
      left--;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_reads(input int target, input int budget);
    int left;
    left = budget;
    while ((rd_count < target) && (left > 0)) begin
      tick(1);
      left--;
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int n,
                             input logic [7:0] start, input logic [7:0] stride, input int exp_len);
    logic [7:0] b;
    int nsof;
    int neof;
    checkOutput({tag, "_count"}, 64'(got_data.size() - base), 64'(n));
    if (got_data.size() >= base + n) begin
      nsof = 0;
      neof = 0;
      for (int i = 0; i < n; i++) begin
        b = start + 8'(i) * stride;
        checkOutput($sformatf("%s_byte%0d", tag, i), 64'(got_data[base + i]), 64'(b));
        nsof += got_sof[base + i] ? 1 : 0;
        neof += got_eof[base + i] ? 1 : 0;
      end
      checkOutput({tag, "_sof"}, 64'(got_sof[base]), 64'd1);
      checkOutput({tag, "_len"}, 64'(got_len[base]), 64'(exp_len));
      checkOutput({tag, "_eof"}, 64'(got_eof[base + n - 1]), 64'd1);
      checkOutput({tag, "_nsof"}, 64'(nsof), 64'd1);
      checkOutput({tag, "_neof"}, 64'(neof), 64'd1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_strobes"},
                64'({bus.ptr_fifo_rd, bus.data_fifo_rd, bus.out_valid,
                     bus.out_sof, bus.out_eof, bus.hdr_valid}), 64'd0);
    checkOutput({tag, "_out"}, 64'({bus.out_data, bus.out_len}), 64'd0);
    checkOutput({tag, "_hdr"}, {bus.hdr_dmac, bus.hdr_etype}, 64'd0);
    checkOutput({tag, "_cnt"}, 64'({bus.cnt_good, bus.cnt_drop}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "[TB] watchdog expired");
  end

  int base;
  int rb;
  int vb;
  int hb;

  initial begin
    rst_sys       = 1'b1;
    bus.out_ready = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_sys       = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);

    // Good 64-byte frame, bytes 0x10..0x4F.
    base = got_data.size();
    hb   = hdr_pulses;
    applyStimulus(16'h003F, 64, 8'h10, 8'h01);
    wait_bytes(base + 64, 2000, 1'b0);
    tick(5);
    check_frame("t1", base, 64, 8'h10, 8'h01, 64);
    checkOutput("t1_hdr_pulses", 64'(hdr_pulses - hb), 64'd1);
    checkOutput("t1_dmac", 64'(last_dmac), 64'h1011_1213_1415);
    checkOutput("t1_etype", 64'(last_etype), 64'h1C1D);
    checkOutput("t1_cnt_good", 64'(bus.cnt_good), 64'd1);
    checkOutput("t1_cnt_drop", 64'(bus.cnt_drop), 64'd0);

    // CRC-error frame is drained silently, then a 20-byte good frame follows.
    rb = rd_count;
    vb = valid_seen;
    applyStimulus(16'h803F, 64, 8'h00, 8'h01);
    wait_reads(rb + 64, 500);
    tick(5);
    checkOutput("t2_reads", 64'(rd_count - rb), 64'd64);
    checkOutput("t2_valid", 64'(valid_seen - vb), 64'd0);
    checkOutput("t2_fifo_left", 64'(data_wp - data_rp), 64'd0);
    checkOutput("t2_cnt_drop", 64'(bus.cnt_drop), 64'd1);
    checkOutput("t2_cnt_good", 64'(bus.cnt_good), 64'd1);
    base = got_data.size();
    applyStimulus(16'h0013, 20, 8'hC0, 8'h01);
    wait_bytes(base + 20, 1000, 1'b0);
    tick(5);
    check_frame("t2b", base, 20, 8'hC0, 8'h01, 20);
    checkOutput("t2b_dmac", 64'(last_dmac), 64'hC0C1_C2C3_C4C5);
    checkOutput("t2b_etype", 64'(last_etype), 64'hCCCD);
    checkOutput("t2b_cnt_good", 64'(bus.cnt_good), 64'd2);

    // 100-byte frame, bytes 0xFF downward, with a ~30% out_ready duty.
    track_pend = 1'b1;
    base = got_data.size();
    applyStimulus(16'h0063, 100, 8'hFF, 8'hFF);
    wait_bytes(base + 100, 5000, 1'b1);
    tick(5);
    track_pend = 1'b0;
    check_frame("t3", base, 100, 8'hFF, 8'hFF, 100);
    checkOutput("t3_pend_viol", 64'(pend_viol), 64'd0);
    checkOutput("t3_dmac", 64'(last_dmac), 64'hFFFE_FDFC_FBFA);
    checkOutput("t3_etype", 64'(last_etype), 64'hF3F2);
    checkOutput("t3_cnt_good", 64'(bus.cnt_good), 64'd3);

    // Single-byte frame: sof and eof together, no header pulse.
    base = got_data.size();
    hb   = hdr_pulses;
    applyStimulus(16'h0000, 1, 8'h77, 8'h01);
    wait_bytes(base + 1, 500, 1'b0);
    tick(5);
    check_frame("t4", base, 1, 8'h77, 8'h01, 1);
    checkOutput("t4_hdr_pulses", 64'(hdr_pulses - hb), 64'd0);
    checkOutput("t4_cnt_good", 64'(bus.cnt_good), 64'd4);

    // Oversize 1523-byte frame is drained; reset then hits mid-XFER of the next one.
    rb = rd_count;
    vb = valid_seen;
    applyStimulus(16'h05F2, 1523, 8'h00, 8'h03);
    wait_reads(rb + 1523, 3000);
    tick(5);
    checkOutput("t5_reads", 64'(rd_count - rb), 64'd1523);
    checkOutput("t5_valid", 64'(valid_seen - vb), 64'd0);
    checkOutput("t5_cnt_drop", 64'(bus.cnt_drop), 64'd2);
    base = got_data.size();
    applyStimulus(16'h003F, 64, 8'h40, 8'h01);
    wait_bytes(base + 5, 500, 1'b0);
    checkOutput("t5_midframe", 64'(got_data.size() - base >= 5), 64'd1);
    rst_sys = 1'b1;
    #1;
    check_all_zero("t5_rst");
    tick(1);
    check_all_zero("t5_rst_hold");
    rst_sys = 1'b0;
    rb = rd_count;
    tick(5);
    checkOutput("t5_idle_strobes",
                64'({bus.ptr_fifo_rd, bus.data_fifo_rd, bus.out_valid}), 64'd0);
    checkOutput("t5_idle_reads", 64'(rd_count - rb), 64'd0);
    base = got_data.size();
    applyStimulus(16'h0000, 1, 8'h5A, 8'h01);
    wait_bytes(base + 1, 500, 1'b0);
    tick(5);
    check_frame("t5r", base, 1, 8'h5A, 8'h01, 1);
    checkOutput("t5r_cnt_good", 64'(bus.cnt_good), 64'd1);
    checkOutput("both_strobes", 64'(both_hi), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
